// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT sequencing controller and the stage FSM:
// configuration word encodings, completion codes and counter widths.
package ntt_pkg;

    typedef enum logic [3:0] {
        CONF_IDLE     = 4'd0,
        CONF_R2_NTT   = 4'd1,
        CONF_R4_NTT   = 4'd2,
        CONF_D2_NTT   = 4'd3,
        CONF_D4_NTT   = 4'd4,
        CONF_R4_INTT  = 4'd5,
        CONF_R2_INTT  = 4'd6,
        CONF_D2_INTT  = 4'd7,
        CONF_D4_INTT  = 4'd8
    } conf_t;

    localparam logic [2:0] FLAG_R2_DONE = 3'b001;
    localparam logic [2:0] FLAG_R4_DONE = 3'b010;

    localparam int unsigned WDOG_W  = 10;
    localparam int unsigned DRAIN_W = 4;

    // True for the states in which a butterfly pass is running.
    function automatic logic is_compute(input conf_t c);
        return (c == CONF_R2_NTT)  || (c == CONF_R4_NTT) ||
               (c == CONF_R4_INTT) || (c == CONF_R2_INTT);
    endfunction

endpackage

// File: rtl/ntt_seq_ctrl_if.sv
// Control/status bundle between the sequencer and its requester/stage FSM.
interface ntt_seq_ctrl_if;

    logic       start;
    logic       mode;
    logic       abort;
    logic [2:0] done_flag;
    logic [3:0] conf;
    logic       busy;
    logic       done;
    logic       err;

    // Requester / stage side: drives requests and completion codes.
    modport master (
        output start, mode, abort, done_flag,
        input  conf, busy, done, err
    );

    // Sequencer side.
    modport slave (
        input  start, mode, abort, done_flag,
        output conf, busy, done, err
    );

endinterface

// File: rtl/ntt_seq_ctrl_drain_timer.sv
// Down-counter holding a DONE state for a loaded number of cycles.
// expire is high in the last held cycle (count reached zero while active).
module drain_timer
    import ntt_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               clear,
    input  logic [DRAIN_W-1:0] load_val,
    output logic               expire
);

    logic [DRAIN_W-1:0] cnt;
    logic               active;

    assign expire = active && (cnt == '0);

    // Load, count down to zero, then go inactive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            active <= 1'b0;
        end else if (clear) begin
            cnt    <= '0;
            active <= 1'b0;
        end else if (load) begin
            cnt    <= load_val;
            active <= 1'b1;
        end else if (active) begin
            if (cnt == '0) begin
                active <= 1'b0;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/ntt_seq_ctrl.sv
// NTT/INTT pass sequencer: steps the stage FSM through radix-2/radix-4
// passes and their write-drain windows, with abort and watchdog exits.
module ntt_seq_ctrl
    import ntt_pkg::*;
#(
    parameter int unsigned DRAIN_R2 = 8,
    parameter int unsigned DRAIN_R4 = 14,
    parameter int unsigned WDOG_MAX = 1023
) (
    input  logic            clk,
    input  logic            rst,
    ntt_seq_ctrl_if.slave   bus
);

    conf_t              state, state_nxt;
    logic [WDOG_W-1:0]  wdog;
    logic               wdog_trip;
    logic               drain_load;
    logic [DRAIN_W-1:0] drain_val;
    logic               drain_expire;
    logic               done_nxt;
    logic               err_set, err_clr;
    logic               busy_q, done_q, err_q;

    localparam logic [DRAIN_W-1:0] LOAD_R2 = DRAIN_W'(DRAIN_R2 - 1);
    localparam logic [DRAIN_W-1:0] LOAD_R4 = DRAIN_W'(DRAIN_R4 - 1);
    localparam logic [WDOG_W-1:0]  WDOG_LAST = WDOG_W'(WDOG_MAX - 1);

    // The count holds cycles already spent, so the trip fires in the
    // WDOG_MAX-th cycle of a compute state.
    assign wdog_trip = is_compute(state) && (wdog == WDOG_LAST);

    assign bus.conf = state;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.err  = err_q;

    drain_timer u_drain (
        .clk      (clk),
        .rst      (rst),
        .load     (drain_load),
        .clear    (state_nxt == CONF_IDLE),
        .load_val (drain_val),
        .expire   (drain_expire)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CONF_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state selection: abort, then watchdog, then normal progress.
    always_comb begin
        state_nxt  = state;
        drain_load = 1'b0;
        drain_val  = '0;
        done_nxt   = 1'b0;
        err_set    = 1'b0;
        err_clr    = 1'b0;
        if (state == CONF_IDLE) begin
            if (bus.start) begin
                state_nxt = bus.mode ? CONF_R4_INTT : CONF_R2_NTT;
                err_clr   = 1'b1;
            end
        end else if (bus.abort) begin
            state_nxt = CONF_IDLE;
        end else if (wdog_trip) begin
            state_nxt = CONF_IDLE;
            err_set   = 1'b1;
        end else begin
            case (state)
                CONF_R2_NTT: if (bus.done_flag == FLAG_R2_DONE) begin
                    state_nxt  = CONF_D2_NTT;
                    drain_load = 1'b1;
                    drain_val  = LOAD_R2;
                end
                CONF_R4_NTT: if (bus.done_flag == FLAG_R4_DONE) begin
                    state_nxt  = CONF_D4_NTT;
                    drain_load = 1'b1;
                    drain_val  = LOAD_R4;
                end
                CONF_R4_INTT: if (bus.done_flag == FLAG_R4_DONE) begin
                    state_nxt  = CONF_D4_INTT;
                    drain_load = 1'b1;
                    drain_val  = LOAD_R4;
                end
                CONF_R2_INTT: if (bus.done_flag == FLAG_R2_DONE) begin
                    state_nxt  = CONF_D2_INTT;
                    drain_load = 1'b1;
                    drain_val  = LOAD_R2;
                end
                CONF_D2_NTT:  if (drain_expire) state_nxt = CONF_R4_NTT;
                CONF_D4_INTT: if (drain_expire) state_nxt = CONF_R2_INTT;
                CONF_D4_NTT, CONF_D2_INTT: if (drain_expire) begin
                    state_nxt = CONF_IDLE;
                    done_nxt  = 1'b1;
                end
                default: state_nxt = CONF_IDLE;
            endcase
        end
    end

    // Watchdog: clear on entering a compute state, count while in one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog <= '0;
        end else if (is_compute(state_nxt) && (state_nxt != state)) begin
            wdog <= '0;
        end else if (is_compute(state)) begin
            wdog <= wdog + 1'b1;
        end
    end

    // Registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= (state_nxt != CONF_IDLE);
            done_q <= done_nxt;
            if (err_clr) begin
                err_q <= 1'b0;
            end else if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ntt_seq_ctrl.sv
// Directed bench for ntt_seq_ctrl: each step drives one cycle of inputs,
// queues the expected outputs, and checks them after the next rising edge.
module tb_ntt_seq_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   compared   = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    ntt_seq_ctrl_if bus ();
    ntt_seq_ctrl_if wbus ();

    ntt_seq_ctrl #(.DRAIN_R2(8), .DRAIN_R4(14), .WDOG_MAX(1023)) dut (
        .clk (clk), .rst (rst), .bus (bus.slave)
    );

    ntt_seq_ctrl #(.DRAIN_R2(8), .DRAIN_R4(14), .WDOG_MAX(15)) dut_wdog (
        .clk (clk), .rst (rst), .bus (wbus.slave)
    );

    typedef struct {
        bit         sel;
        logic [3:0] conf;
        logic       busy;
        logic       done;
        logic       err;
        string      tag;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input bit sel, input logic [3:0] c,
                           input logic b, input logic d, input logic e);
        if (!sel) begin
            chk({tag, ".conf"}, bus.conf, c);
            chk({tag, ".busy"}, {3'b0, bus.busy}, {3'b0, b});
            chk({tag, ".done"}, {3'b0, bus.done}, {3'b0, d});
            chk({tag, ".err"},  {3'b0, bus.err},  {3'b0, e});
        end else begin
            chk({tag, ".conf"}, wbus.conf, c);
            chk({tag, ".busy"}, {3'b0, wbus.busy}, {3'b0, b});
            chk({tag, ".done"}, {3'b0, wbus.done}, {3'b0, d});
            chk({tag, ".err"},  {3'b0, wbus.err},  {3'b0, e});
        end
    endtask

    // One cycle: drive inputs, queue expectation, compare after the edge.
    task automatic step(input bit sel, input logic s, input logic m, input logic a,
                        input logic [2:0] f, input logic [3:0] ec, input logic eb,
                        input logic ed, input logic ee, input string tag);
        exp_t e;
        exp_t g;
        @(negedge clk);
        if (!sel) begin
            bus.start = s; bus.mode = m; bus.abort = a; bus.done_flag = f;
        end else begin
            wbus.start = s; wbus.mode = m; wbus.abort = a; wbus.done_flag = f;
        end
        e.sel = sel; e.conf = ec; e.busy = eb; e.done = ed; e.err = ee; e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        chk_all(g.tag, g.sel, g.conf, g.busy, g.done, g.err);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        bus.start = 0;  bus.mode = 0;  bus.abort = 0;  bus.done_flag = '0;
        wbus.start = 0; wbus.mode = 0; wbus.abort = 0; wbus.done_flag = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_all("reset", 0, 4'd0, 0, 0, 0);
        chk_all("reset_w", 1, 4'd0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        step(0, 0, 0, 0, 3'b000, 4'd0, 0, 0, 0, "idle");

        // NTT: 1 (20 cycles) -> 3 (8) -> 2 -> 4 (14) -> 0 with done
        step(0, 1, 0, 0, 3'b000, 4'd1, 1, 0, 0, "ntt_start");
        for (int i = 0; i < 19; i++) step(0, 0, 0, 0, 3'b000, 4'd1, 1, 0, 0, "ntt_r2");
        step(0, 0, 0, 0, 3'b001, 4'd3, 1, 0, 0, "ntt_r2_done");
        for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 3'b000, 4'd3, 1, 0, 0, "ntt_drain2");
        step(0, 0, 0, 0, 3'b000, 4'd2, 1, 0, 0, "ntt_r4_enter");
        step(0, 1, 1, 0, 3'b000, 4'd2, 1, 0, 0, "ntt_start_ignored");
        step(0, 0, 0, 0, 3'b001, 4'd2, 1, 0, 0, "ntt_wrong_code");
        step(0, 0, 0, 0, 3'b011, 4'd2, 1, 0, 0, "ntt_other_code");
        step(0, 0, 0, 0, 3'b010, 4'd4, 1, 0, 0, "ntt_r4_done");
        for (int i = 0; i < 13; i++) step(0, 0, 0, 0, 3'b000, 4'd4, 1, 0, 0, "ntt_drain4");
        step(0, 0, 0, 0, 3'b000, 4'd0, 0, 1, 0, "ntt_finish");
        step(0, 0, 0, 0, 3'b000, 4'd0, 0, 0, 0, "ntt_done_pulse_end");

        // INTT: 5 -> 8 (14) -> 6 -> 7 (8) -> 0 with done
        step(0, 1, 1, 0, 3'b000, 4'd5, 1, 0, 0, "intt_start");
        step(0, 0, 0, 0, 3'b001, 4'd5, 1, 0, 0, "intt_wrong_code");
        step(0, 0, 0, 0, 3'b010, 4'd8, 1, 0, 0, "intt_r4_done");
        for (int i = 0; i < 13; i++) step(0, 0, 0, 0, 3'b000, 4'd8, 1, 0, 0, "intt_drain4");
        step(0, 0, 0, 0, 3'b000, 4'd6, 1, 0, 0, "intt_r2_enter");
        step(0, 0, 0, 0, 3'b010, 4'd6, 1, 0, 0, "intt_wrong_code2");
        step(0, 0, 0, 0, 3'b001, 4'd7, 1, 0, 0, "intt_r2_done");
        for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 3'b000, 4'd7, 1, 0, 0, "intt_drain2");
        step(0, 0, 0, 0, 3'b000, 4'd0, 0, 1, 0, "intt_finish");
        step(0, 0, 0, 0, 3'b000, 4'd0, 0, 0, 0, "intt_done_pulse_end");

        // Abort beats done_flag in the same cycle
        step(0, 1, 0, 0, 3'b000, 4'd1, 1, 0, 0, "abort_start");
        step(0, 0, 0, 1, 3'b001, 4'd0, 0, 0, 0, "abort_vs_flag");
        step(0, 0, 0, 0, 3'b000, 4'd0, 0, 0, 0, "abort_idle");

        // Abort beats drain expiry in the last DONE cycle
        step(0, 1, 0, 0, 3'b000, 4'd1, 1, 0, 0, "abx_start");
        step(0, 0, 0, 0, 3'b001, 4'd3, 1, 0, 0, "abx_r2_done");
        for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 3'b000, 4'd3, 1, 0, 0, "abx_drain2");
        step(0, 0, 0, 1, 3'b000, 4'd0, 0, 0, 0, "abort_vs_expire");

        // Reset mid-run during conf=4
        step(0, 1, 0, 0, 3'b000, 4'd1, 1, 0, 0, "rst_start");
        step(0, 0, 0, 0, 3'b001, 4'd3, 1, 0, 0, "rst_r2_done");
        for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 3'b000, 4'd3, 1, 0, 0, "rst_drain2");
        step(0, 0, 0, 0, 3'b000, 4'd2, 1, 0, 0, "rst_r4_enter");
        step(0, 0, 0, 0, 3'b010, 4'd4, 1, 0, 0, "rst_r4_done");
        step(0, 0, 0, 0, 3'b000, 4'd4, 1, 0, 0, "rst_drain4");
        #2;
        rst = 1'b1;
        #1;
        chk_all("rst_async", 0, 4'd0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 3'b000, 4'd0, 0, 0, 0, "rst_stay_idle");

        // Watchdog (WDOG_MAX=15): 15 cycles in state 1, then err and IDLE
        step(1, 1, 0, 0, 3'b000, 4'd1, 1, 0, 0, "wd_start");
        for (int i = 0; i < 14; i++) step(1, 0, 0, 0, 3'b000, 4'd1, 1, 0, 0, "wd_r2");
        step(1, 0, 0, 0, 3'b000, 4'd0, 0, 0, 1, "wd_trip");
        step(1, 0, 0, 0, 3'b000, 4'd0, 0, 0, 1, "wd_err_sticky");
        step(1, 0, 0, 1, 3'b000, 4'd0, 0, 0, 1, "wd_abort_idle");
        step(1, 1, 0, 0, 3'b000, 4'd1, 1, 0, 0, "wd_restart_clears");
        step(1, 0, 0, 1, 3'b000, 4'd0, 0, 0, 0, "wd_abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ntt_seq_ctrl.md
NTT_SEQ_CTRL -- requirements
Module: ntt_seq_ctrl

Interface
REQ-001 Parameter DRAIN_R2, default 8: DONE-state hold cycles after the radix-2 pass, covering the sel=0 write pipeline.
REQ-002 Parameter DRAIN_R4, default 14: DONE-state hold cycles after the radix-4 pass, covering the sel=1 write pipeline.
REQ-003 Parameter WDOG_MAX, default 1023: maximum cycles allowed in one compute state.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  request to begin one transform; sampled only in IDLE.
REQ-007 mode  input  1  transform type, sampled with start: 0 = NTT, 1 = INTT.
REQ-008 abort  input  1  synchronous abandon of the current transform.
REQ-009 done_flag  input  3  completion code from the stage FSM: 3'b001 = radix-2 pass done, 3'b010 = radix-4 pass done.
REQ-010 conf  output  4  registered configuration word driven to the stage FSM.
REQ-011 busy  output  1  high from the cycle after start is accepted until the return to IDLE.
REQ-012 done  output  1  one-cycle pulse on normal completion.
REQ-013 err  output  1  sticky watchdog error; cleared by the next accepted start or by rst.

Function
REQ-014 conf encodings SHALL be: IDLE=0, RADIX2_NTT=1, RADIX4_NTT=2, DONE_RADIX2_NTT=3, DONE_RADIX4_NTT=4, RADIX4_INTT=5, RADIX2_INTT=6, DONE_RADIX2_INTT=7, DONE_RADIX4_INTT=8.
REQ-015 NTT sequence SHALL be: 1 -> 3 -> 2 -> 4 -> 0.
REQ-016 INTT sequence SHALL be: 5 -> 8 -> 6 -> 7 -> 0.
REQ-017 start=1 in IDLE SHALL set conf to the first compute code on the next edge; busy SHALL rise on that same edge.
REQ-018 start while busy=1 SHALL be ignored.
REQ-019 In a radix-2 compute state, done_flag==3'b001 SHALL move conf to the matching DONE code on the next edge.
REQ-020 In a radix-4 compute state, done_flag==3'b010 SHALL move conf to the matching DONE code on the next edge.
REQ-021 Any other done_flag value, including the code for the other radix, SHALL keep conf unchanged.
REQ-022 A DONE state SHALL hold exactly DRAIN_R2 (radix-2) or DRAIN_R4 (radix-4) cycles, then advance.
REQ-023 On leaving the final DONE state, conf SHALL return to 0, busy SHALL fall, and done SHALL pulse high for one cycle on that same edge.
REQ-024 A watchdog counter SHALL clear on entry to each compute state and increment every cycle within it.
REQ-025 When the watchdog count reaches WDOG_MAX, the block SHALL set err=1, set conf=0 and busy=0 on the next edge, and not pulse done.
REQ-026 abort=1 in any non-IDLE state SHALL set conf=0 and busy=0 on the next edge, with no done pulse and err unchanged.
REQ-027 abort takes priority over done_flag and over drain expiry in the same cycle.
REQ-028 The watchdog counter SHALL be 10 bits wide and the drain counter 4 bits wide; parameter values wider than these widths are illegal.
REQ-029 All outputs SHALL be registered; no combinational path from any input to conf, busy, done or err.

Reset
REQ-030 rst SHALL asynchronously force conf=0, busy=0, done=0, err=0 and clear both counters.
REQ-031 rst asserted mid-transform SHALL abandon the transform; after rst releases, a new start is required.

Structure
REQ-032 The conf encodings and done_flag codes SHALL live in shared package ntt_pkg, which the stage FSM also uses.
REQ-033 The drain timing SHALL be a sub-module drain_timer: load value, count down, expire pulse.

Verification
REQ-034 NTT: start=1, mode=0; bench asserts done_flag=001 at cycle 20 -> conf 1 for cycles 1-20, then 3 for 8 cycles, then 2; bench asserts done_flag=010 -> conf 4 for 14 cycles, then 0 with done pulse and busy falling on the same edge.
REQ-035 INTT: start=1, mode=1 -> conf sequence 5, 8, 6, 7, 0, with the radix-4 drain of 14 cycles and the radix-2 drain of 8 cycles.
REQ-036 Ignored start and wrong code: start pulsed while conf=2 -> no effect; done_flag=001 while conf=2 -> conf stays 2.
REQ-037 Abort: abort=1 in the same cycle as done_flag=001 in conf=1 -> conf=0 next edge, done=0, err=0.
REQ-038 Watchdog: WDOG_MAX=15, done_flag held at 0 -> err=1 and conf=0 after 15 cycles in state 1; the next start clears err.
REQ-039 Reset mid-run: rst pulsed during conf=4 -> all outputs 0 immediately; conf stays 0 until a new start.
